// File: rtl/md_ring_pkg.sv
// Shared types and widths for the ring injector: packet layout, payload layout
// and the drain FSM state encoding.
package md_ring_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int PARTICLE_ID_WIDTH = 7;
  localparam int NODE_ID_WIDTH     = 6;
  localparam int FORCE_CACHE_WIDTH = 3 * DATA_WIDTH;
  localparam int FORCE_DATA_WIDTH  = FORCE_CACHE_WIDTH + PARTICLE_ID_WIDTH;
  localparam int PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] pid;
    logic [FORCE_CACHE_WIDTH-1:0] frc;   // {fz,fy,fx}, fx in the LSBs
  } payload_t;

  typedef struct packed {
    logic [NODE_ID_WIDTH-1:0] dest;
    payload_t                 payload;
  } packet_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } inj_state_t;

  function automatic packet_t make_packet(
    input logic [NODE_ID_WIDTH-1:0]     dest,
    input logic [PARTICLE_ID_WIDTH-1:0] pid,
    input logic [FORCE_CACHE_WIDTH-1:0] frc
  );
    packet_t p;
    p.dest        = dest;
    p.payload.pid = pid;
    p.payload.frc = frc;
    return p;
  endfunction

endpackage

// File: rtl/ring_injector_if.sv
// Force-input and PE-inject handshake bundle of one ring injector.
// slave = injector side, master = force pipeline / ring node / controller side.
interface ring_injector_if;
  import md_ring_pkg::*;

  logic                         in_valid;
  logic [PARTICLE_ID_WIDTH-1:0] in_pid;
  logic [FORCE_CACHE_WIDTH-1:0] in_force;
  logic [NODE_ID_WIDTH-1:0]     in_dest;
  logic                         in_ready;
  logic                         almost_full;
  logic                         flush;
  logic [PACKET_WIDTH-1:0]      pe_pkt_out;
  logic                         pe_pkt_valid;
  logic                         pe_ready;
  logic                         busy;
  logic                         done;

  modport slave (
    input  in_valid, in_pid, in_force, in_dest, flush, pe_ready,
    output in_ready, almost_full, pe_pkt_out, pe_pkt_valid, busy, done
  );

  modport master (
    output in_valid, in_pid, in_force, in_dest, flush, pe_ready,
    input  in_ready, almost_full, pe_pkt_out, pe_pkt_valid, busy, done
  );

endinterface

// File: rtl/ring_inj_fifo.sv
// Show-ahead (first-word-fall-through) FIFO with occupancy count, full/empty
// and a registered almost-full flag.
module ring_inj_fifo #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 8,
  parameter  int AF_MARGIN = 2,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             afull_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      afull_q <= ((DEPTH - int'(count_d)) <= AF_MARGIN);
    end
  end

  // Storage is data only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign afull_o = afull_q;

endmodule

// File: rtl/ring_injector.sv
// PE-side ring transmitter: packetizes force results, buffers them and runs the
// flush/drain/done sequence. Optional counters enabled by RING_INJ_STATS_EN.
module ring_injector
  import md_ring_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  parameter  int AF_MARGIN  = 2,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  ring_injector_if.slave   bus
`ifdef RING_INJ_STATS_EN
  ,
  output logic [31:0]      stat_pkts,
  output logic [31:0]      stat_stall,
  output logic [CW-1:0]    stat_maxocc
`endif
);

  packet_t                 in_pkt;
  logic [PACKET_WIDTH-1:0] head_vec;
  logic [CW-1:0]           count;
  logic                    full, empty, afull;
  logic                    push, pop;
  inj_state_t              state_q;
  logic                    done_q;

  assign in_pkt = make_packet(bus.in_dest, bus.in_pid, bus.in_force);

  // When full, a ready ring node frees the head this edge, so the push can land.
  assign bus.in_ready = ~full | bus.pe_ready;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = ~empty & bus.pe_ready;

  ring_inj_fifo #(
    .WIDTH     (PACKET_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_pkt),
    .rdata_o (head_vec),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty),
    .afull_o (afull)
  );

  assign bus.pe_pkt_valid = ~empty;
  assign bus.pe_pkt_out   = empty ? '0 : head_vec;
  assign bus.almost_full  = afull;
  assign bus.busy         = (count != '0) | (state_q != IDLE);
  assign bus.done         = done_q;

  // DRAIN keeps accepting the pipeline tail; it only finishes on an empty,
  // push-free cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE:    if (bus.flush) state_q <= DRAIN;
        DRAIN:   if (empty && !push) begin
                   state_q <= DONE;
                   done_q  <= 1'b1;
                 end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RING_INJ_STATS_EN
  logic [31:0]   stat_pkts_q, stat_stall_q;
  logic [CW-1:0] stat_maxocc_q;
  logic          stat_clr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign stat_clr = (state_q == IDLE) & bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_q   <= '0;
      stat_stall_q  <= '0;
      stat_maxocc_q <= '0;
    end else if (stat_clr) begin
      stat_pkts_q   <= '0;
      stat_stall_q  <= '0;
      stat_maxocc_q <= '0;
    end else begin
      if (pop)                 stat_pkts_q   <= sat_inc(stat_pkts_q);
      if (~empty & ~bus.pe_ready) stat_stall_q <= sat_inc(stat_stall_q);
      if (count > stat_maxocc_q) stat_maxocc_q <= count;
    end
  end

  assign stat_pkts   = stat_pkts_q;
  assign stat_stall  = stat_stall_q;
  assign stat_maxocc = stat_maxocc_q;
`endif

endmodule

// File: tb/tb_ring_injector.sv
// Self-checking bench for ring_injector: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_ring_injector;
  import md_ring_pkg::*;

  localparam int DEPTH = 8;
  localparam int AFM   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ring_injector_if bus();

`ifdef RING_INJ_STATS_EN
  logic [31:0] stat_pkts, stat_stall;
  logic [3:0]  stat_maxocc;
`endif

  ring_injector #(.FIFO_DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RING_INJ_STATS_EN
    ,
    .stat_pkts   (stat_pkts),
    .stat_stall  (stat_stall),
    .stat_maxocc (stat_maxocc)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: packet queue, almost-full flag, drain phase (0 idle, 1 draining, 2 done).
  logic [PACKET_WIDTH-1:0] mq[$];
  bit          af_m;
  int          phase;
  int unsigned m_pkts, m_stall, m_maxocc;

  task automatic chk(input string name, input logic [PACKET_WIDTH-1:0] act,
                     input logic [PACKET_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    af_m = 1'b0;
    phase = 0;
    m_pkts = 0;
    m_stall = 0;
    m_maxocc = 0;
  endtask

  task automatic check_model();
    logic [PACKET_WIDTH-1:0] eo;
    eo = (mq.size() != 0) ? mq[0] : '0;
    chk("pe_pkt_valid", bus.pe_pkt_valid, mq.size() != 0);
    chk("pe_pkt_out", bus.pe_pkt_out, eo);
    chk("in_ready", bus.in_ready, (mq.size() < DEPTH) || bus.pe_ready);
    chk("almost_full", bus.almost_full, af_m);
    chk("busy", bus.busy, (mq.size() != 0) || (phase != 0));
    chk("done", bus.done, phase == 2);
`ifdef RING_INJ_STATS_EN
    chk("stat_pkts", stat_pkts, m_pkts);
    chk("stat_stall", stat_stall, m_stall);
    chk("stat_maxocc", stat_maxocc, m_maxocc);
`endif
  endtask

  task automatic model_step();
    int n;
    bit pop, push;
    n    = mq.size();
    pop  = (n > 0) && bus.pe_ready;
    push = bus.in_valid && ((n < DEPTH) || bus.pe_ready);
    if (phase == 0 && bus.flush) begin
      m_pkts = 0; m_stall = 0; m_maxocc = 0;
    end else begin
      if (pop && m_pkts != 32'hFFFF_FFFF) m_pkts++;
      if (n > 0 && !bus.pe_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (n > m_maxocc) m_maxocc = n;
    end
    case (phase)
      0: if (bus.flush) phase = 1;
      1: if (n == 0 && !push) phase = 2;
      default: phase = 0;
    endcase
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back({bus.in_dest, bus.in_pid, bus.in_force});
    af_m = (DEPTH - mq.size()) <= AFM;
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic drive(input logic v, input logic [6:0] pid, input logic [95:0] frc,
                       input logic [5:0] dest, input logic rdy, input logic fl);
    bus.in_valid = v;
    bus.in_pid   = pid;
    bus.in_force = frc;
    bus.in_dest  = dest;
    bus.pe_ready = rdy;
    bus.flush    = fl;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  function automatic logic [95:0] rnd_force();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    logic                    v;
    logic [6:0]              pid;
    logic [95:0]             frc;
    logic [5:0]              dest;
    logic                    rdy;
    logic                    fl;
    logic                    e_valid;
    logic [PACKET_WIDTH-1:0] e_out;
    logic                    e_busy;
    logic                    e_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    packet_t p;
    int      got, exp_pid;
    bit      seen_done;

    model_reset();
    idle(1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", bus.pe_pkt_valid, 1'b0);
    chk("reset_out", bus.pe_pkt_out, '0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_almost_full", bus.almost_full, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    rst_n = 1'b1;

    // Single push/pop latency, then flush with an empty FIFO and a repeated flush in DRAIN.
    tbl[0] = '{1'b1, 7'd5, {32'd3, 32'd2, 32'd1}, 6'd9, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 7'd0, 96'd0, 6'd0, 1'b1, 1'b0, 1'b1,
               {6'd9, 7'd5, 32'd3, 32'd2, 32'd1}, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 7'd0, 96'd0, 6'd0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 7'd0, 96'd0, 6'd0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 7'd0, 96'd0, 6'd0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 7'd0, 96'd0, 6'd0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 7'd0, 96'd0, 6'd0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].pid, tbl[i].frc, tbl[i].dest, tbl[i].rdy, tbl[i].fl);
      sample();
      chk($sformatf("vec%0d_valid", i), bus.pe_pkt_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_out", i), bus.pe_pkt_out, tbl[i].e_out);
      chk($sformatf("vec%0d_busy", i), bus.busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i), bus.done, tbl[i].e_done);
      advance();
    end

    // Backpressure: fill to 8 with the ring node stalled.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 7'(i), rnd_force(), 6'(i), 1'b0, 1'b0);
      tick();
    end
    idle(1'b0);
    sample();
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_almost_full", bus.almost_full, 1'b1);
    advance();

    // Full FIFO with simultaneous push and pop.
    drive(1'b1, 7'd8, rnd_force(), 6'd8, 1'b1, 1'b0);
    sample();
    chk("full_pushpop_in_ready", bus.in_ready, 1'b1);
    advance();
    idle(1'b0);
    sample();
    chk("full_after_pushpop", bus.in_ready, 1'b0);
    advance();

    got = 0;
    exp_pid = 1;
    for (int i = 0; i < 12; i++) begin
      idle(1'b1);
      sample();
      if (bus.pe_pkt_valid) begin
        p = bus.pe_pkt_out;
        chk("order_pid", p.payload.pid, 7'(exp_pid));
        exp_pid++;
        got++;
      end
      advance();
    end
    chk("order_count", 32'(got), 32'd8);

    // Drain with three queued packets and a toggling ring node.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'(20 + i), rnd_force(), 6'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1); tick();
    idle(1'b0); tick();
    idle(1'b1); tick();
    idle(1'b1); tick();
    seen_done = 1'b0;
    for (int i = 0; i < 8 && !seen_done; i++) begin
      idle(1'b1);
      sample();
      if (bus.done) seen_done = 1'b1;
      advance();
    end
    chk("drain_done_seen", seen_done, 1'b1);
    idle(1'b1);
    sample();
    chk("drain_busy_after", bus.busy, 1'b0);
    advance();

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(40 + i), rnd_force(), 6'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1); tick();
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.pe_pkt_valid, 1'b0);
    chk("async_rst_out", bus.pe_pkt_out, '0);
    chk("async_rst_in_ready", bus.in_ready, 1'b1);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_almost_full", bus.almost_full, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      tick();
    end

    // Ten transfers with four stall cycles in the middle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 7'(60 + i), rnd_force(), 6'(i), 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 7'(70 + i), rnd_force(), 6'(i), 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      tick();
    end
`ifdef RING_INJ_STATS_EN
    chk("stats_pkts10", stat_pkts, 32'd10);
    chk("stats_stall4", stat_stall, 32'd4);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 99) < 60), 7'($urandom()), rnd_force(), 6'($urandom()),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      idle(1'b1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
